// File: rtl/adder_serial.sv
// Digit-serial adder/subtractor: latches operands, then consumes DIGIT bits per cycle from the
// LSB end and holds the registered result until the consumer takes it.
module adder_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic                   carry;
    logic                   a_msb;
    logic                   b_msb;
    logic [CNT_W-1:0]       cnt;
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] shifted;

    // One digit of the ripple: low DIGIT bits of each operand plus the running carry.
    assign dsum    = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Widened so the shift-in also works when a single digit spans the whole word.
    assign shifted = {dsum[DIGIT-1:0], sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa      <= a;
                        opb      <= sub ? ~b : b;
                        carry    <= sub ? ~carry_in : carry_in;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1] ^ sub;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    carry <= dsum[DIGIT];
                    sum   <= shifted[WIDTH+DIGIT-1:DIGIT];
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        carry_out <= dsum[DIGIT];
                        // The top bit of the final digit is the result sign bit.
                        overflow  <= (a_msb == b_msb) && (dsum[DIGIT-1] != a_msb);
                        cnt       <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_serial.sv
// Bench for adder_serial: an 8-bit bit-serial instance plus 4-bit instances with 2-bit and
// 4-bit digits, all checked against an integer reference model.
module tb_adder_serial;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       iv8 = 0, ord8 = 0, ci8 = 0, sub8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       ir8, ov8, co8, of8, busy8;
    logic [7:0] s8;

    logic       iv4 = 0, ord4 = 0, ci4 = 0, sub4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic       ir42, ov42, co42, of42, busy42;
    logic [3:0] s42;
    logic       ir44, ov44, co44, of44, busy44;
    logic [3:0] s44;

    adder_serial #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .carry_in(ci8), .sub(sub8), .out_valid(ov8), .out_ready(ord8), .sum(s8),
        .carry_out(co8), .overflow(of8), .busy(busy8));

    adder_serial #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir42), .a(a4), .b(b4),
        .carry_in(ci4), .sub(sub4), .out_valid(ov42), .out_ready(ord4), .sum(s42),
        .carry_out(co42), .overflow(of42), .busy(busy42));

    adder_serial #(.WIDTH(4), .DIGIT(4)) u44 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir44), .a(a4), .b(b4),
        .carry_in(ci4), .sub(sub4), .out_valid(ov44), .out_ready(ord4), .sum(s44),
        .carry_out(co44), .overflow(of44), .busy(busy44));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer arithmetic, unsigned for sum/carry, signed for overflow.
    function automatic void model(input int w, input int a, input int b, input bit ci,
                                  input bit sub, output int s, output bit co, output bit ov);
        int r, sa, sb, rs, half;
        half = 1 << (w - 1);
        r  = sub ? a - b - int'(ci) : a + b + int'(ci);
        s  = r & ((1 << w) - 1);
        co = sub ? (r >= 0) : (r >= (1 << w));
        sa = (a >= half) ? a - (1 << w) : a;
        sb = (b >= half) ? b - (1 << w) : b;
        rs = sub ? sa - sb - int'(ci) : sa + sb + int'(ci);
        ov = (rs < -half) || (rs >= half);
    endfunction

    // One 8-bit transaction: accept, wait for the result, hold it `hold` cycles, then drain.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit ci, input bit sub,
                        input int hold, input string name);
        int  es, lat;
        bit  eco, eov;
        logic [7:0] hs;
        logic hco, hov;
        model(8, int'(a), int'(b), ci, sub, es, eco, eov);
        a8 = a; b8 = b; ci8 = ci; sub8 = sub; iv8 = 1;
        total++;
        if (ir8 !== 1'b1) begin bad++; $display("FAIL %s ready: got %b want 1", name, ir8); end
        tick();
        iv8 = 0; a8 = $urandom; b8 = $urandom;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (ov8 === 1'b1) break;
            tick();
            lat = i;
        end
        total++;
        if (lat !== 8 || ov8 !== 1'b1) begin
            bad++; $display("FAIL %s latency: got %0d (ov=%b) want 8", name, lat, ov8);
        end
        total++;
        if ({co8, of8, s8} !== {eco, eov, 8'(es)}) begin
            bad++;
            $display("FAIL %s result: got co=%b ov=%b sum=%h want co=%b ov=%b sum=%h",
                     name, co8, of8, s8, eco, eov, 8'(es));
        end
        hs = s8; hco = co8; hov = of8;
        for (int i = 0; i < hold; i++) begin
            iv8 = 1; a8 = $urandom; b8 = $urandom; sub8 = $urandom; ci8 = $urandom;
            tick();
            total++;
            if ({ov8, ir8, s8, co8, of8} !== {1'b1, 1'b0, hs, hco, hov}) begin
                bad++;
                $display("FAIL %s hold%0d: got ov=%b rdy=%b sum=%h co=%b of=%b want 1 0 %h %b %b",
                         name, i, ov8, ir8, s8, co8, of8, hs, hco, hov);
            end
        end
        iv8 = 0;
        ord8 = 1;
        tick();
        ord8 = 0;
        total++;
        if ({ov8, ir8, busy8} !== 3'b010) begin
            bad++; $display("FAIL %s drain: got ov/rdy/busy=%b%b%b want 010", name, ov8, ir8, busy8);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        total++;
        if ({ir8, ov8, busy8, s8, co8, of8} !== {3'b100, 8'h00, 2'b00}) begin
            bad++;
            $display("FAIL reset8: got rdy=%b ov=%b busy=%b sum=%h co=%b of=%b want 1 0 0 00 0 0",
                     ir8, ov8, busy8, s8, co8, of8);
        end
        total++;
        if ({ir42, ov42, busy42, s42, co42, of42, ir44, ov44, busy44, s44, co44, of44}
            !== {3'b100, 4'h0, 2'b00, 3'b100, 4'h0, 2'b00}) begin
            bad++; $display("FAIL reset4: got %b%b%b %h %b%b / %b%b%b %h %b%b want 100 0 00",
                            ir42, ov42, busy42, s42, co42, of42, ir44, ov44, busy44, s44, co44, of44);
        end
        ord8 = 1;
        tick();
        ord8 = 0;
        total++;
        if ({ir8, ov8, busy8} !== 3'b100) begin
            bad++; $display("FAIL idle_out_ready: got %b%b%b want 100", ir8, ov8, busy8);
        end
    endtask

    task automatic test_directed();
        run8(8'hFF, 8'h01, 0, 0, 0, "ff_plus_1");
        run8(8'h7F, 8'h01, 0, 0, 0, "7f_plus_1");
        run8(8'h05, 8'h07, 0, 1, 0, "5_minus_7");
        run8(8'h80, 8'h01, 0, 1, 0, "80_minus_1");
        run8(8'hFF, 8'hFF, 1, 0, 0, "ff_ff_c1");
        run8(8'h00, 8'h00, 1, 1, 0, "0_minus_0_b1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0, "random8");
    endtask

    task automatic test_hold();
        run8(8'h3C, 8'h55, 1, 0, 5, "hold_add");
        run8(8'hA1, 8'h7E, 0, 1, 5, "hold_sub");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0, "b2b");
    endtask

    task automatic test_abort();
        a8 = 8'h12; b8 = 8'h34; ci8 = 0; sub8 = 0; iv8 = 1;
        tick();
        iv8 = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        total++;
        if ({ir8, busy8, ov8} !== 3'b100) begin
            bad++; $display("FAIL abort_state: got rdy/busy/ov=%b%b%b want 100", ir8, busy8, ov8);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (ov8 !== 1'b0) begin bad++; $display("FAIL abort_quiet%0d: got ov=%b want 0", i, ov8); end
        end
        run8(8'h12, 8'h34, 0, 0, 0, "after_abort");
    endtask

    task automatic test_exhaustive4();
        int  es, l42, l44;
        bit  eco, eov;
        for (int v = 0; v < 1024; v++) begin
            a4 = 4'(v); b4 = 4'(v >> 4); ci4 = v[8]; sub4 = v[9];
            model(4, v & 15, (v >> 4) & 15, v[8], v[9], es, eco, eov);
            iv4 = 1;
            tick();
            iv4 = 0;
            l42 = -1; l44 = -1;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (ov42 === 1'b1 && l42 < 0) l42 = k;
                if (ov44 === 1'b1 && l44 < 0) l44 = k;
                if (l42 >= 0 && l44 >= 0) break;
            end
            total++;
            if (l42 !== 2 || l44 !== 1) begin
                bad++; $display("FAIL lat4 v=%0d: got d2=%0d d4=%0d want 2 1", v, l42, l44);
            end
            total++;
            if ({co42, of42, s42, co44, of44, s44} !== {eco, eov, 4'(es), eco, eov, 4'(es)}) begin
                bad++;
                $display("FAIL res4 v=%0d: got d2 %b%b %h d4 %b%b %h want %b%b %h",
                         v, co42, of42, s42, co44, of44, s44, eco, eov, 4'(es));
            end
            ord4 = 1;
            tick();
            ord4 = 0;
            total++;
            if ({ir42, ov42, ir44, ov44} !== 4'b1010) begin
                bad++; $display("FAIL drain4 v=%0d: got %b%b%b%b want 1010", v, ir42, ov42, ir44, ov44);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_abort();
        test_exhaustive4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
